fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: four-phase instruction sequencer with program counter,
// jump/call/return redirection and a return-address stack.
// Ports:
//   clk, reset (sync, active-high), start/start_addr (begin from IDLE),
//   jump/call/ret/target/halt_req (sampled only at stage 11),
//   pc, stage, running, done, stk_ovf, stk_unf (sticky stack errors).
module fetch_sequencer #(
   parameter int PCWidth    = 10,
   parameter int StackDepth = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [PCWidth-1:0] start_addr,
   input  logic               jump,
   input  logic               call,
   input  logic               ret,
   input  logic [PCWidth-1:0] target,
   input  logic               halt_req,
   output logic [PCWidth-1:0] pc,
   output logic [1:0]         stage,
   output logic               running,
   output logic               done,
   output logic               stk_ovf,
   output logic               stk_unf
);

   localparam int SpW      = $clog2(StackDepth + 1);
   localparam int IdxW     = (StackDepth > 1) ? $clog2(StackDepth) : 1;
   localparam int StackLen = 1 << IdxW;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   logic [1:0]         state;
   logic [SpW-1:0]     sp;
   logic [PCWidth-1:0] stk [StackLen];
   logic [PCWidth-1:0] pc_inc;
   logic [IdxW-1:0]    push_idx;
   logic [IdxW-1:0]    top_idx;
   logic               stk_full;
   logic               stk_empty;

   assign pc_inc    = pc + PCWidth'(1);
   assign push_idx  = IdxW'(sp);
   assign top_idx   = IdxW'(sp - SpW'(1));
   assign stk_full  = (sp == SpW'(StackDepth));
   assign stk_empty = (sp == '0);
   assign running   = (state == RUN);
   assign done      = (state == HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= '0;
         stage   <= 2'b00;
         sp      <= '0;
         stk_ovf <= 1'b0;
         stk_unf <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               stage <= 2'b00;
               if (start) begin
                  pc    <= start_addr;
                  state <= RUN;
               end
            end
            RUN: begin
               // Stage wraps 11->00, so every exit to HALT lands on 00.
               stage <= stage + 2'd1;
               if (stage == 2'b11) begin
                  if (halt_req) begin
                     state <= HALT;
                  end else if (jump && call) begin
                     if (stk_full) begin
                        stk_ovf <= 1'b1;
                        state   <= HALT;
                     end else begin
                        stk[push_idx] <= pc_inc;
                        sp            <= sp + SpW'(1);
                        pc            <= target;
                     end
                  end else if (jump && ret) begin
                     if (stk_empty) begin
                        stk_unf <= 1'b1;
                        state   <= HALT;
                     end else begin
                        pc <= stk[top_idx];
                        sp <= sp - SpW'(1);
                     end
                  end else if (jump) begin
                     pc <= target;
                  end else begin
                     pc <= pc_inc;
                  end
               end
            end
            HALT: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random stimulus for fetch_sequencer,
// checked every cycle against a queue-based reference model.
module tb_fetch_sequencer;

   localparam int PCW   = 10;
   localparam int DEPTH = 4;
   localparam int PCMOD = 1 << PCW;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [PCW-1:0] start_addr;
   logic           jump;
   logic           call;
   logic           ret;
   logic [PCW-1:0] target;
   logic           halt_req;
   logic [PCW-1:0] pc;
   logic [1:0]     stage;
   logic           running;
   logic           done;
   logic           stk_ovf;
   logic           stk_unf;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   int m_pc;
   int m_stage;
   bit m_running;
   bit m_done;
   bit m_ovf;
   bit m_unf;
   int m_stack[$];

   fetch_sequencer #(.PCWidth(PCW), .StackDepth(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .jump       (jump),
      .call       (call),
      .ret        (ret),
      .target     (target),
      .halt_req   (halt_req),
      .pc         (pc),
      .stage      (stage),
      .running    (running),
      .done       (done),
      .stk_ovf    (stk_ovf),
      .stk_unf    (stk_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      if (reset) begin
         m_pc = 0; m_stage = 0; m_running = 0; m_done = 0;
         m_ovf = 0; m_unf = 0;
         m_stack.delete();
      end else if (m_running) begin
         if (m_stage == 3) begin
            if (halt_req) begin
               m_running = 0; m_done = 1;
            end else if (jump && call) begin
               if (m_stack.size() == DEPTH) begin
                  m_ovf = 1; m_running = 0; m_done = 1;
               end else begin
                  m_stack.push_back((m_pc + 1) % PCMOD);
                  m_pc = int'(target);
               end
            end else if (jump && ret) begin
               if (m_stack.size() == 0) begin
                  m_unf = 1; m_running = 0; m_done = 1;
               end else begin
                  m_pc = m_stack.pop_back();
               end
            end else if (jump) begin
               m_pc = int'(target);
            end else begin
               m_pc = (m_pc + 1) % PCMOD;
            end
         end
         m_stage = (m_stage + 1) % 4;
      end else if (!m_done && start) begin
         m_pc = int'(start_addr); m_stage = 0; m_running = 1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      #1;
      chk("pc", int'(pc), m_pc);
      chk("stage", int'(stage), m_stage);
      chk("running", int'(running), int'(m_running));
      chk("done", int'(done), int'(m_done));
      chk("stk_ovf", int'(stk_ovf), int'(m_ovf));
      chk("stk_unf", int'(stk_unf), int'(m_unf));
   endtask

   task automatic idle_inputs();
      reset = 0; start = 0; jump = 0; call = 0; ret = 0;
      halt_req = 0; start_addr = '0; target = '0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      step();
      reset = 0;
   endtask

   task automatic do_start(input int addr);
      start_addr = PCW'(addr);
      start = 1;
      step();
      start = 0;
   endtask

   // bounded advance until the model reaches the wanted stage
   task automatic to_stage(input int s);
      int guard = 0;
      while (m_stage != s && guard < 8) begin
         step();
         guard++;
      end
      chk("reach_stage", int'(stage), s);
   endtask

   task automatic redirect(input bit j, input bit c, input bit r,
                           input int tgt);
      to_stage(3);
      jump = j; call = c; ret = r; target = PCW'(tgt);
      step();
      jump = 0; call = 0; ret = 0;
   endtask

   initial begin
      idle_inputs();
      reset = 1;
      step();
      step();
      chk("rst_pc", int'(pc), 0);
      chk("rst_running", int'(running), 0);
      reset = 0;

      // sequential run from 5
      do_start(5);
      chk("seq_running", int'(running), 1);
      chk("seq_pc0", int'(pc), 5);
      steps(4);
      chk("seq_pc1", int'(pc), 6);
      steps(4);
      chk("seq_pc2", int'(pc), 7);
      start_addr = PCW'(100);
      start = 1;
      steps(4);
      start = 0;
      chk("start_in_run", int'(pc), 8);

      // wrap, ignored early jump, real jump
      do_reset();
      do_start(1023);
      steps(4);
      chk("wrap_pc", int'(pc), 0);
      to_stage(1);
      jump = 1; target = PCW'(40);
      step();
      jump = 0;
      to_stage(0);
      chk("early_jump_ignored", int'(pc), 1);
      redirect(1, 0, 0, 40);
      chk("jump_pc", int'(pc), 40);
      to_stage(3);
      call = 1; ret = 1; target = PCW'(500);
      step();
      call = 0; ret = 0;
      chk("qual_no_jump", int'(pc), 41);

      // call then return
      do_reset();
      do_start(10);
      redirect(1, 0, 0, 10);
      redirect(1, 1, 0, 100);
      chk("call_pc", int'(pc), 100);
      steps(16);
      chk("callee_pc", int'(pc), 104);
      redirect(1, 0, 1, 0);
      chk("ret_pc", int'(pc), 11);
      redirect(1, 1, 1, 300);
      chk("call_beats_ret", int'(pc), 300);
      redirect(1, 0, 1, 0);
      chk("ret2_pc", int'(pc), 12);
      redirect(1, 0, 1, 0);
      chk("empty_after_ret", int'(stk_unf), 1);

      // overflow on fifth nested call
      do_reset();
      do_start(0);
      for (int k = 0; k < 5; k++) redirect(1, 1, 0, 200 + k * 10);
      chk("ovf_flag", int'(stk_ovf), 1);
      chk("ovf_done", int'(done), 1);
      chk("ovf_pc", int'(pc), 230);
      steps(5);

      // underflow on fresh start
      do_reset();
      do_start(50);
      redirect(1, 0, 1, 0);
      chk("unf_flag", int'(stk_unf), 1);
      chk("unf_done", int'(done), 1);
      chk("unf_pc", int'(pc), 50);

      // halt freezes everything
      do_reset();
      do_start(20);
      to_stage(3);
      halt_req = 1;
      step();
      halt_req = 0;
      chk("halt_done", int'(done), 1);
      chk("halt_pc", int'(pc), 20);
      chk("halt_stage", int'(stage), 0);
      do_start(7);
      steps(6);
      chk("halt_frozen_pc", int'(pc), 20);

      // reset mid-instruction after two calls
      do_reset();
      do_start(0);
      redirect(1, 1, 0, 60);
      redirect(1, 1, 0, 70);
      to_stage(2);
      reset = 1;
      step();
      reset = 0;
      chk("midrst_pc", int'(pc), 0);
      chk("midrst_stage", int'(stage), 0);
      chk("midrst_running", int'(running), 0);
      do_start(3);
      chk("restart_pc", int'(pc), 3);
      redirect(1, 0, 1, 0);
      chk("midrst_stack_empty", int'(stk_unf), 1);

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset      = ($urandom_range(0, 99) == 0);
         start      = ($urandom_range(0, 9) == 0);
         start_addr = PCW'($urandom_range(0, PCMOD - 1));
         jump       = ($urandom_range(0, 2) == 0);
         call       = ($urandom_range(0, 2) == 0);
         ret        = ($urandom_range(0, 2) == 0);
         target     = PCW'($urandom_range(0, PCMOD - 1));
         halt_req   = ($urandom_range(0, 49) == 0);
         if (m_done && $urandom_range(0, 3) == 0) reset = 1;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
